// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: stall/flush
// generation, execute/decode forwarding selects, and a mult/div occupancy sequencer.
module hazard_controller #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_is_branch,
    input  logic             d_uses_rt,
    input  logic [4:0]       e_rs,
    input  logic [4:0]       e_rt,
    input  logic [4:0]       e_wa,
    input  logic             e_rf_we,
    input  logic             e_is_load,
    input  logic             e_md_start,
    input  logic             e_md_is_div,
    input  logic [4:0]       m_wa,
    input  logic             m_rf_we,
    input  logic             m_is_load,
    input  logic [4:0]       w_wa,
    input  logic             w_rf_we,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             f_stall,
    output logic             d_stall,
    output logic             e_stall,
    output logic             d_flush,
    output logic             e_flush,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             fwd_a_d,
    output logic             fwd_b_d,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_count,
    output logic [0:0]       md_state
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int MD_W       = $clog2(MAX_CYCLES + 1);

    localparam logic [MD_W-1:0] MULT_LOAD = MD_W'(MULT_CYCLES - 1);
    localparam logic [MD_W-1:0] DIV_LOAD  = MD_W'(DIV_CYCLES - 1);
    localparam logic [MD_W-1:0] MD_ONE    = MD_W'(1);

    logic [0:0]      state;
    logic [MD_W-1:0] md_cnt;

    logic e_match;
    logic m_match;
    logic lw_stall;
    logic br_stall;
    logic hz;
    logic md_start;
    logic md_hold;

    assign md_state = state;

    // A destination "matches" decode when it is a nonzero register read by decode.
    assign e_match = (e_wa != 5'd0) && ((e_wa == d_rs) || (d_uses_rt && (e_wa == d_rt)));
    assign m_match = (m_wa != 5'd0) && ((m_wa == d_rs) || (d_uses_rt && (m_wa == d_rt)));

    assign lw_stall = e_rf_we && e_is_load && e_match;
    assign br_stall = d_is_branch && ((e_rf_we && e_match) || (m_is_load && m_match));
    assign hz       = lw_stall || br_stall;

    // The start cycle stalls combinationally so the op never slips out of execute.
    assign md_start = (state == IDLE) && e_md_start;
    assign md_busy  = (state == MD_BUSY);
    assign md_hold  = md_start || md_busy;
    assign md_done  = md_busy && (md_cnt == MD_ONE);

    assign f_stall = hz || md_hold;
    assign d_stall = hz || md_hold;
    assign e_stall = md_hold;
    assign e_flush = hz && !md_hold;
    assign d_flush = (branch_taken || jump) && !hz && !md_busy;

    always_comb begin
        fwd_a_e = 2'b00;
        if (m_rf_we && (m_wa != 5'd0) && (m_wa == e_rs)) begin
            fwd_a_e = 2'b10;
        end else if (w_rf_we && (w_wa != 5'd0) && (w_wa == e_rs)) begin
            fwd_a_e = 2'b01;
        end
    end

    always_comb begin
        fwd_b_e = 2'b00;
        if (m_rf_we && (m_wa != 5'd0) && (m_wa == e_rt)) begin
            fwd_b_e = 2'b10;
        end else if (w_rf_we && (w_wa != 5'd0) && (w_wa == e_rt)) begin
            fwd_b_e = 2'b01;
        end
    end

    // Loads in memory have no data yet, so the branch comparator cannot take them.
    assign fwd_a_d = m_rf_we && !m_is_load && (m_wa != 5'd0) && (m_wa == d_rs);
    assign fwd_b_d = m_rf_we && !m_is_load && (m_wa != 5'd0) && (m_wa == d_rt);

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (e_md_start) begin
                        state  <= MD_BUSY;
                        md_cnt <= e_md_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                MD_BUSY: begin
                    md_cnt <= md_cnt - MD_ONE;
                    if (md_cnt == MD_ONE) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    md_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (f_stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed scenarios plus randomized traffic checked
// against an occupancy-based reference model.
module tb_hazard_controller;

    logic       clock;
    logic       reset;
    logic [4:0] d_rs, d_rt, e_rs, e_rt, e_wa, m_wa, w_wa;
    logic       d_is_branch, d_uses_rt, e_rf_we, e_is_load, e_md_start, e_md_is_div;
    logic       m_rf_we, m_is_load, w_rf_we, branch_taken, jump;

    logic        f_stall, d_stall, e_stall, d_flush, e_flush, fwd_a_d, fwd_b_d;
    logic [1:0]  fwd_a_e, fwd_b_e;
    logic        md_busy, md_done;
    logic [15:0] stall_count;
    logic [0:0]  md_state;

    logic        s_f_stall, s_d_stall, s_e_stall, s_d_flush, s_e_flush, s_fwd_a_d, s_fwd_b_d;
    logic [1:0]  s_fwd_a_e, s_fwd_b_e;
    logic        s_md_busy, s_md_done;
    logic [3:0]  s_stall_count;
    logic [0:0]  s_md_state;

    int checks = 0;
    int errors = 0;

    hazard_controller dut (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_is_branch(d_is_branch), .d_uses_rt(d_uses_rt), .e_rs(e_rs), .e_rt(e_rt),
        .e_wa(e_wa), .e_rf_we(e_rf_we), .e_is_load(e_is_load), .e_md_start(e_md_start),
        .e_md_is_div(e_md_is_div), .m_wa(m_wa), .m_rf_we(m_rf_we), .m_is_load(m_is_load),
        .w_wa(w_wa), .w_rf_we(w_rf_we), .branch_taken(branch_taken), .jump(jump),
        .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .d_flush(d_flush),
        .e_flush(e_flush), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d),
        .fwd_b_d(fwd_b_d), .md_busy(md_busy), .md_done(md_done),
        .stall_count(stall_count), .md_state(md_state)
    );

    hazard_controller #(.CNT_W(4)) sat_dut (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_is_branch(d_is_branch), .d_uses_rt(d_uses_rt), .e_rs(e_rs), .e_rt(e_rt),
        .e_wa(e_wa), .e_rf_we(e_rf_we), .e_is_load(e_is_load), .e_md_start(e_md_start),
        .e_md_is_div(e_md_is_div), .m_wa(m_wa), .m_rf_we(m_rf_we), .m_is_load(m_is_load),
        .w_wa(w_wa), .w_rf_we(w_rf_we), .branch_taken(branch_taken), .jump(jump),
        .f_stall(s_f_stall), .d_stall(s_d_stall), .e_stall(s_e_stall), .d_flush(s_d_flush),
        .e_flush(s_e_flush), .fwd_a_e(s_fwd_a_e), .fwd_b_e(s_fwd_b_e), .fwd_a_d(s_fwd_a_d),
        .fwd_b_d(s_fwd_b_d), .md_busy(s_md_busy), .md_done(s_md_done),
        .stall_count(s_stall_count), .md_state(s_md_state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    // An op occupies execute for len cycles; ref_pos counts cycles already spent.
    bit          ref_active;
    int          ref_len;
    int          ref_pos;
    int          ref_cnt;
    int          ref_cnt4;

    function automatic logic ref_match(input logic [4:0] x, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (x != 0) && ((x == rs) || (uses_rt && (x == rt)));
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] src, input logic mwe,
                                           input logic [4:0] mwa, input logic wwe,
                                           input logic [4:0] wwa);
        if (src != 0 && mwe && mwa == src) return 2'd2;
        if (src != 0 && wwe && wwa == src) return 2'd1;
        return 2'd0;
    endfunction

    logic exp_hz, exp_hold, exp_busy, exp_done, exp_f_stall, exp_e_flush, exp_d_flush;
    logic [1:0] exp_fa_e, exp_fb_e;
    logic exp_fa_d, exp_fb_d;

    assign exp_hz = (e_rf_we && e_is_load && ref_match(e_wa, d_rs, d_rt, d_uses_rt)) ||
                    (d_is_branch && ((e_rf_we && ref_match(e_wa, d_rs, d_rt, d_uses_rt)) ||
                                     (m_is_load && ref_match(m_wa, d_rs, d_rt, d_uses_rt))));
    assign exp_hold    = ref_active || e_md_start;
    assign exp_busy    = ref_active;
    assign exp_done    = ref_active && (ref_pos == ref_len - 1);
    assign exp_f_stall = exp_hz || exp_hold;
    assign exp_e_flush = exp_hz && !exp_hold;
    assign exp_d_flush = (branch_taken || jump) && !exp_hz && !exp_busy;
    assign exp_fa_e    = ref_fwd(e_rs, m_rf_we, m_wa, w_rf_we, w_wa);
    assign exp_fb_e    = ref_fwd(e_rt, m_rf_we, m_wa, w_rf_we, w_wa);
    assign exp_fa_d    = m_rf_we && !m_is_load && m_wa != 0 && m_wa == d_rs;
    assign exp_fb_d    = m_rf_we && !m_is_load && m_wa != 0 && m_wa == d_rt;

    always @(posedge clock) begin
        if (reset) begin
            ref_active = 1'b0;
            ref_len    = 0;
            ref_pos    = 0;
            ref_cnt    = 0;
            ref_cnt4   = 0;
        end else begin
            if (exp_f_stall) begin
                if (ref_cnt < 65535) ref_cnt = ref_cnt + 1;
                if (ref_cnt4 < 15) ref_cnt4 = ref_cnt4 + 1;
            end
            if (ref_active) begin
                ref_pos = ref_pos + 1;
                if (ref_pos == ref_len) ref_active = 1'b0;
            end else if (e_md_start) begin
                ref_active = 1'b1;
                ref_len    = e_md_is_div ? 32 : 4;
                ref_pos    = 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        d_rs = 0; d_rt = 0; e_rs = 0; e_rt = 0; e_wa = 0; m_wa = 0; w_wa = 0;
        d_is_branch = 0; d_uses_rt = 0; e_rf_we = 0; e_is_load = 0; e_md_start = 0;
        e_md_is_div = 0; m_rf_we = 0; m_is_load = 0; w_rf_we = 0; branch_taken = 0; jump = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        next_cycle();
        clear_inputs();
        reset = 1'b1;
        next_cycle();
        @(negedge clock);
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0) begin
            errors++; $display("FAIL reset_md: busy=%0b done=%0b expected 0 0", md_busy, md_done);
        end
        checks++;
        if (stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", stall_count);
        end
        checks++;
        if ({f_stall, d_stall, e_stall, d_flush, e_flush} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000",
                               {f_stall, d_stall, e_stall, d_flush, e_flush});
        end
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        e_wa = 2; e_rf_we = 1; e_is_load = 1; d_rs = 2;
        @(negedge clock);
        checks++;
        if ({f_stall, d_stall, e_flush, e_stall} !== 4'b1110) begin
            errors++; $display("FAIL load_use_stall: f/d/eflush/estall=%b expected 1110",
                               {f_stall, d_stall, e_flush, e_stall});
        end
        next_cycle();
        clear_inputs();
        d_rs = 2; m_wa = 2; m_rf_we = 1; m_is_load = 1;
        @(negedge clock);
        checks++;
        if ({f_stall, e_flush, fwd_a_d} !== 3'b000) begin
            errors++; $display("FAIL load_use_release: f/eflush/fwd_a_d=%b expected 000",
                               {f_stall, e_flush, fwd_a_d});
        end
        next_cycle();
        clear_inputs();
        e_rs = 2; w_wa = 2; w_rf_we = 1;
        @(negedge clock);
        checks++;
        if (fwd_a_e !== 2'b01) begin
            errors++; $display("FAIL load_use_fwd: fwd_a_e=%b expected 01", fwd_a_e);
        end
        checks++;
        if (stall_count !== 16'd1) begin
            errors++; $display("FAIL load_use_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_fwd_priority();
        next_cycle();
        clear_inputs();
        m_wa = 5; m_rf_we = 1; w_wa = 5; w_rf_we = 1; e_rs = 5; e_rt = 5;
        @(negedge clock);
        checks++;
        if (fwd_a_e !== 2'b10 || fwd_b_e !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_prio: a=%b b=%b expected 10 10", fwd_a_e, fwd_b_e);
        end
        next_cycle();
        m_rf_we = 0; e_rt = 7;
        @(negedge clock);
        checks++;
        if (fwd_a_e !== 2'b01 || fwd_b_e !== 2'b00) begin
            errors++; $display("FAIL fwd_wb: a=%b b=%b expected 01 00", fwd_a_e, fwd_b_e);
        end
        next_cycle();
        m_rf_we = 1; m_wa = 0; w_wa = 0; e_rs = 0; e_rt = 0; d_rs = 0;
        @(negedge clock);
        checks++;
        if (fwd_a_e !== 2'b00 || fwd_b_e !== 2'b00 || fwd_a_d !== 1'b0) begin
            errors++; $display("FAIL fwd_r0: a=%b b=%b ad=%b expected 00 00 0",
                               fwd_a_e, fwd_b_e, fwd_a_d);
        end
    endtask

    task automatic test_branch();
        next_cycle();
        clear_inputs();
        d_is_branch = 1; d_rs = 3; e_wa = 3; e_rf_we = 1; branch_taken = 1;
        @(negedge clock);
        checks++;
        if ({f_stall, d_flush, e_flush} !== 3'b101) begin
            errors++; $display("FAIL branch_stall: f/dflush/eflush=%b expected 101",
                               {f_stall, d_flush, e_flush});
        end
        next_cycle();
        e_wa = 0; e_rf_we = 0; m_wa = 3; m_rf_we = 1; m_is_load = 0;
        @(negedge clock);
        checks++;
        if ({f_stall, fwd_a_d, d_flush} !== 3'b011) begin
            errors++; $display("FAIL branch_resolve: f/fwd_a_d/dflush=%b expected 011",
                               {f_stall, fwd_a_d, d_flush});
        end
        next_cycle();
        clear_inputs();
        d_is_branch = 1; d_uses_rt = 1; d_rt = 6; m_wa = 6; m_is_load = 1; m_rf_we = 1; jump = 1;
        @(negedge clock);
        checks++;
        if ({f_stall, d_flush, fwd_b_d} !== 3'b100) begin
            errors++; $display("FAIL branch_load_mem: f/dflush/fwd_b_d=%b expected 100",
                               {f_stall, d_flush, fwd_b_d});
        end
    endtask

    task automatic test_md(input bit is_div);
        int len;
        len = is_div ? 32 : 4;
        do_reset();
        for (int i = 0; i < len + 2; i++) begin
            e_md_start = (i < len); e_md_is_div = is_div;
            @(negedge clock);
            checks++;
            if (e_stall !== (i < len) || md_busy !== (i >= 1 && i < len) ||
                md_done !== (i == len - 1) || e_flush !== 1'b0) begin
                errors++; $display("FAIL md_seq div=%0d cycle %0d: stall/busy/done/eflush=%b%b%b%b",
                                   is_div, i, e_stall, md_busy, md_done, e_flush);
            end
            next_cycle();
        end
        @(negedge clock);
        checks++;
        if (stall_count !== 16'(len)) begin
            errors++; $display("FAIL md_count div=%0d: got %0d expected %0d", is_div, stall_count, len);
        end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        e_md_start = 1; e_md_is_div = 1;
        for (int i = 0; i <= 10; i++) begin
            if (i == 10) begin
                reset = 1'b1;
                e_md_start = 0;
            end
            @(negedge clock);
            if (i == 10) begin
                checks++;
                if (md_busy !== 1'b1) begin
                    errors++; $display("FAIL mid_div_busy: got %0b expected 1", md_busy);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({md_busy, md_done, f_stall, e_stall} !== 4'b0 || stall_count !== 16'd0) begin
            errors++; $display("FAIL mid_div_abort: busy/done/f/e=%b count=%0d expected 0000 0",
                               {md_busy, md_done, f_stall, e_stall}, stall_count);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (md_done !== 1'b0 || md_busy !== 1'b0) begin
            errors++; $display("FAIL mid_div_idle: busy=%0b done=%0b expected 0 0", md_busy, md_done);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        e_wa = 4; e_rf_we = 1; e_is_load = 1; d_rs = 4;
        for (int i = 0; i < 20; i++) next_cycle();
        clear_inputs();
        @(negedge clock);
        checks++;
        if (s_stall_count !== 4'd15) begin
            errors++; $display("FAIL sat_count4: got %0d expected 15", s_stall_count);
        end
        checks++;
        if (stall_count !== 16'd20) begin
            errors++; $display("FAIL sat_count16: got %0d expected 20", stall_count);
        end
    endtask

    task automatic test_random();
        logic [12:0] obs, exp_v;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            d_rs         = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
            e_rs         = 5'($urandom_range(0, 3)); e_rt = 5'($urandom_range(0, 3));
            e_wa         = 5'($urandom_range(0, 3)); m_wa = 5'($urandom_range(0, 3));
            w_wa         = 5'($urandom_range(0, 3));
            d_is_branch  = 1'($urandom_range(0, 1)); d_uses_rt = 1'($urandom_range(0, 1));
            e_rf_we      = 1'($urandom_range(0, 1)); e_is_load = 1'($urandom_range(0, 1));
            e_md_start   = ($urandom_range(0, 5) == 0);
            e_md_is_div  = ($urandom_range(0, 3) == 0);
            m_rf_we      = 1'($urandom_range(0, 1)); m_is_load = 1'($urandom_range(0, 1));
            w_rf_we      = 1'($urandom_range(0, 1));
            branch_taken = 1'($urandom_range(0, 1)); jump = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            obs   = {f_stall, d_stall, e_stall, d_flush, e_flush, md_busy, md_done,
                     fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d};
            exp_v = {exp_f_stall, exp_f_stall, exp_hold, exp_d_flush, exp_e_flush, exp_busy,
                     exp_done, exp_fa_e, exp_fb_e, exp_fa_d, exp_fb_d};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random_ctrl cycle %0d: got %b expected %b", i, obs, exp_v);
            end
            checks++;
            if (stall_count !== 16'(ref_cnt) || s_stall_count !== 4'(ref_cnt4)) begin
                errors++; $display("FAIL random_count cycle %0d: got %0d/%0d expected %0d/%0d",
                                   i, stall_count, s_stall_count, ref_cnt, ref_cnt4);
            end
            next_cycle();
        end
        reset = 1'b0;
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_fwd_priority();
        test_branch();
        test_md(1'b0);
        test_md(1'b1);
        test_reset_mid_div();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS datapath; replaces the instruction-decode-only flusher.
- Generates per-stage stall/flush controls, execute-stage and decode-stage (branch compare) forwarding selects, and a multi-cycle mult/div busy sequencer.
- Keeps a saturating stall counter for the debug bus.

Parameters:
- MULT_CYCLES, 4, execute-stage occupancy of a mult op in cycles (>=2)
- DIV_CYCLES, 32, execute-stage occupancy of a div op in cycles (>=2)
- CNT_W, 16, width of stall_count

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- d_rs, d_rt  input  5 each  source registers of the instruction in decode
- d_is_branch  input  1  decode instruction is BEQ
- d_uses_rt  input  1  decode instruction reads rt as a source
- e_rs, e_rt  input  5 each  source registers in execute
- e_wa  input  5  resolved write address in execute
- e_rf_we  input  1  execute writes the RF
- e_is_load  input  1  execute is LW (sel_result = DMEM)
- e_md_start  input  1  execute holds a mult/div op
- e_md_is_div  input  1  1 = div, 0 = mult; valid with e_md_start
- m_wa  input  5  write address in memory stage
- m_rf_we, m_is_load  input  1 each  memory-stage write enable / load flag
- w_wa  input  5  write address in writeback
- w_rf_we  input  1  writeback write enable
- branch_taken  input  1  branch resolved taken in decode
- jump  input  1  J/JAL detected at fetch
- f_stall, d_stall, e_stall  output  1 each  hold the named pipeline register
- d_flush, e_flush  output  1 each  bubble the named pipeline register
- fwd_a_e, fwd_b_e  output  2 each  ALU operand select: 00 RF, 01 writeback result, 10 memory alu_out
- fwd_a_d, fwd_b_d  output  1 each  branch comparator takes memory alu_out
- md_busy  output  1  mult/div sequencer active
- md_done  output  1  one-cycle pulse on the final busy cycle
- stall_count  output  CNT_W  cycles with f_stall=1, saturating

Behaviour:
- Reset (synchronous): FSM -> IDLE, md counter 0, stall_count 0, md_busy 0, md_done 0. Combinational outputs then follow their equations.
- Forwarding (combinational):
  - fwd_a_e = 10 if m_rf_we & m_wa!=0 & m_wa==e_rs; else 01 if w_rf_we & w_wa!=0 & w_wa==e_rs; else 00. Memory stage has priority.
  - fwd_b_e is the same equation using e_rt.
  - fwd_a_d = m_rf_we & ~m_is_load & m_wa!=0 & m_wa==d_rs. fwd_b_d uses d_rt.
  - Register 0 never forwards.
- match_d(x) = x!=0 & (x==d_rs | (d_uses_rt & x==d_rt)).
- lw_stall = e_rf_we & e_is_load & match_d(e_wa).
- br_stall = d_is_branch & ((e_rf_we & match_d(e_wa)) | (m_is_load & match_d(m_wa))).
- hz = lw_stall | br_stall. When hz: f_stall=1, d_stall=1, e_flush=1 for that cycle. Held decode is re-evaluated next cycle.
- Redirect: d_flush = (branch_taken | jump) & ~hz & ~md_busy. A stall or busy suppresses the flush; the branch re-resolves once released.
- FSM, IDLE:
  - e_md_start=1 -> MD_BUSY; counter loads (e_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - The start cycle itself already asserts f_stall, d_stall and e_stall (combinational on e_md_start in IDLE).
- FSM, MD_BUSY:
  - md_busy=1; f_stall=d_stall=e_stall=1; e_flush=0; counter decrements each cycle.
  - At counter==1: md_done=1. Next cycle -> IDLE, e_stall=0.
  - Total execute occupancy = MULT_CYCLES or DIV_CYCLES cycles including the start cycle.
  - e_md_start while busy is ignored (same op held).
- Priority: md_busy/start overrides hz. While busy, e_flush=0 so the held op is never lost; hazard stalls resume after release if still present.
- stall_count: +1 each cycle f_stall=1; holds at 2^CNT_W-1.
- Reset mid-op: MD_BUSY aborted, next cycle IDLE, md_done not pulsed.

Test Plan:
- LW r2 in execute (e_wa=2, e_is_load=1), decode reads d_rs=2 -> f_stall=d_stall=e_flush=1 for exactly 1 cycle; then with m_wa=2, w_rf_we path, fwd_a_e=01 next cycles as pipeline advances.
- m_wa=5,m_rf_we=1 and w_wa=5,w_rf_we=1, e_rs=5 -> fwd_a_e=10. Same with e_rs=0, wa=0 -> 00.
- BEQ in decode with e_wa=3,e_rf_we=1, d_rs=3, branch_taken=1 -> 1 stall cycle, d_flush=0. Next cycle m_wa=3 non-load -> fwd_a_d=1, d_flush=1.
- e_md_start=1,e_md_is_div=0 -> e_stall high 4 cycles, md_done on cycle 4, IDLE on cycle 5; div gives 32 cycles; stall_count advances by 4 and 32 respectively.
- reset asserted on busy cycle 10 of a div -> next cycle md_busy=0, stalls 0, stall_count=0, no md_done.
- Force f_stall continuously with CNT_W=4 -> stall_count saturates at 15.
